mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_if.sv | 29 ++
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Memory bus between the fetch/data arbiter and an SRAM-like slave.
// One address phase (req/addr_ok) then one data phase (data_ok).
interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          mem_req;
   logic          mem_wr;
   logic [1:0]    mem_size;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_addr_ok;
   logic          mem_data_ok;
   logic [DW-1:0] mem_rdata;

   modport master (
      output mem_req, mem_wr, mem_size,
      output mem_addr, mem_wdata,
      input  mem_addr_ok, mem_data_ok,
      input  mem_rdata
   );

   modport slave (
      input  mem_req, mem_wr, mem_size,
      input  mem_addr, mem_wdata,
      output mem_addr_ok, mem_data_ok,
      output mem_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data sides; data wins.
// Completed results are held until the owning stage advances.
module mem_port_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inst_req,
   input  logic [AW-1:0] inst_addr,
   input  logic          inst_accept,
   output logic [DW-1:0] inst_rdata,
   output logic          imem_busy,
   input  logic          data_req,
   input  logic          data_wr,
   input  logic [1:0]    data_size,
   input  logic [AW-1:0] data_addr,
   input  logic [DW-1:0] data_wdata,
   input  logic          data_accept,
   output logic [DW-1:0] data_rdata,
   output logic          dmem_busy,
   mem_port_arbiter_if.master bus
);
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      D_ADDR = 3'd1,
      D_DATA = 3'd2,
      I_ADDR = 3'd3,
      I_DATA = 3'd4
   } state_e;

   state_e        state_q, state_d;
   logic          mem_wr_q, mem_wr_d;
   logic [1:0]    mem_size_q, mem_size_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic          i_done_q, i_done_d;
   logic          d_done_q, d_done_d;
   logic [DW-1:0] i_buf_q, i_buf_d;
   logic [DW-1:0] d_buf_q, d_buf_d;

   logic i_start, d_start, i_cmp, d_cmp;

   always_comb begin
      d_start = data_req && !d_done_q;
      i_start = inst_req && !i_done_q;
      i_cmp   = (state_q == I_DATA) && bus.mem_data_ok;
      d_cmp   = (state_q == D_DATA) && bus.mem_data_ok;
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (d_start)      state_d = D_ADDR;
            else if (i_start) state_d = I_ADDR;
         end
         D_ADDR: if (bus.mem_addr_ok) state_d = D_DATA;
         D_DATA: if (bus.mem_data_ok) state_d = IDLE;
         I_ADDR: if (bus.mem_addr_ok) state_d = I_DATA;
         I_DATA: if (bus.mem_data_ok) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A dropped requester still lets the bus finish but never sets done.
   always_comb begin
      mem_wr_d    = mem_wr_q;
      mem_size_d  = mem_size_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if (state_q == IDLE) begin
         if (d_start) begin
            mem_wr_d    = data_wr;
            mem_size_d  = data_size;
            mem_addr_d  = data_addr;
            mem_wdata_d = data_wdata;
         end else if (i_start) begin
            mem_wr_d   = 1'b0;
            mem_size_d = 2'd2;
            mem_addr_d = inst_addr;
         end
      end
      i_buf_d = i_cmp ? bus.mem_rdata : i_buf_q;
      d_buf_d = d_cmp ? bus.mem_rdata : d_buf_q;
      i_done_d = i_done_q;
      if (inst_accept)              i_done_d = 1'b0;
      else if (i_cmp && inst_req)   i_done_d = 1'b1;
      d_done_d = d_done_q;
      if (data_accept)              d_done_d = 1'b0;
      else if (d_cmp && data_req)   d_done_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_wr_q    <= 1'b0;
         mem_size_q  <= 2'd0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         i_done_q    <= 1'b0;
         d_done_q    <= 1'b0;
         i_buf_q     <= '0;
         d_buf_q     <= '0;
      end else begin
         mem_wr_q    <= mem_wr_d;
         mem_size_q  <= mem_size_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         i_done_q    <= i_done_d;
         d_done_q    <= d_done_d;
         i_buf_q     <= i_buf_d;
         d_buf_q     <= d_buf_d;
      end
   end

   always_comb begin
      bus.mem_req   = (state_q == D_ADDR) || (state_q == I_ADDR);
      bus.mem_wr    = mem_wr_q;
      bus.mem_size  = mem_size_q;
      bus.mem_addr  = mem_addr_q;
      bus.mem_wdata = mem_wdata_q;
      imem_busy  = inst_req && !i_done_q && !i_cmp;
      dmem_busy  = data_req && !d_done_q && !d_cmp;
      inst_rdata = i_cmp ? bus.mem_rdata : i_buf_q;
      data_rdata = d_cmp ? bus.mem_rdata : d_buf_q;
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed cases, then random traffic
// checked against a transaction-level model of the shared port.
module tb_mem_port_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req, inst_accept, imem_busy;
   logic [31:0] inst_addr, inst_rdata;
   logic        data_req, data_wr, data_accept, dmem_busy;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata, data_rdata;

   mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

   mem_port_arbiter #(.AW(32), .DW(32)) dut (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_addr(inst_addr),
      .inst_accept(inst_accept), .inst_rdata(inst_rdata),
      .imem_busy(imem_busy),
      .data_req(data_req), .data_wr(data_wr),
      .data_size(data_size), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_accept(data_accept),
      .data_rdata(data_rdata), .dmem_busy(dmem_busy),
      .bus(bus.master)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Model: at most one outstanding transfer, owned by one side.
   bit          m_act, m_acc, m_side;  // m_side: 1 = data
   bit          tx_wr;
   bit   [1:0]  tx_size;
   logic [31:0] tx_addr, tx_wdata;
   bit          m_idone, m_ddone;
   logic [31:0] m_ibuf, m_dbuf;

   task automatic model_reset();
      m_act = 0; m_acc = 0; m_side = 0;
      m_idone = 0; m_ddone = 0;
      m_ibuf = '0; m_dbuf = '0;
   endtask

   function automatic bit comp_now();
      return m_act && m_acc && bus.mem_data_ok;
   endfunction

   task automatic tick();
      bit comp, ic, dc, ni, nd;
      @(negedge clk);
      comp = comp_now();
      ic = comp && !m_side;
      dc = comp && m_side;
      check("mem_req", bus.mem_req, m_act && !m_acc);
      if (m_act && !m_acc) begin
         check("mem_addr", bus.mem_addr, tx_addr);
         check("mem_wr", bus.mem_wr, tx_wr);
         check("mem_size", bus.mem_size, tx_size);
         if (tx_wr) check("mem_wdata", bus.mem_wdata, tx_wdata);
      end
      check("imem_busy", imem_busy, inst_req && !m_idone && !ic);
      check("dmem_busy", dmem_busy, data_req && !m_ddone && !dc);
      check("inst_rdata", inst_rdata, ic ? bus.mem_rdata : m_ibuf);
      check("data_rdata", data_rdata, dc ? bus.mem_rdata : m_dbuf);
      if (rst) begin
         model_reset();
      end else begin
         ni = inst_accept ? 0 : ((ic && inst_req) ? 1 : m_idone);
         nd = data_accept ? 0 : ((dc && data_req) ? 1 : m_ddone);
         if (ic) m_ibuf = bus.mem_rdata;
         if (dc) m_dbuf = bus.mem_rdata;
         if (!m_act) begin
            if (data_req && !m_ddone) begin
               m_act = 1; m_acc = 0; m_side = 1;
               tx_addr = data_addr; tx_wr = data_wr;
               tx_size = data_size; tx_wdata = data_wdata;
            end else if (inst_req && !m_idone) begin
               m_act = 1; m_acc = 0; m_side = 0;
               tx_addr = inst_addr; tx_wr = 0; tx_size = 2;
            end
         end else if (!m_acc) begin
            if (bus.mem_addr_ok) m_acc = 1;
         end else if (comp) begin
            m_act = 0;
         end
         m_idone = ni;
         m_ddone = nd;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit ib, db;
      rst = 1;
      inst_req = 0; inst_addr = '0; inst_accept = 0;
      data_req = 0; data_wr = 0; data_size = 0;
      data_addr = '0; data_wdata = '0; data_accept = 0;
      bus.mem_addr_ok = 0; bus.mem_data_ok = 0; bus.mem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      rst = 0;
      #2;
      check("rst mem_req", bus.mem_req, 0);
      check("rst mem_wr", bus.mem_wr, 0);
      check("rst mem_size", bus.mem_size, 0);
      check("rst mem_addr", bus.mem_addr, 0);
      check("rst mem_wdata", bus.mem_wdata, 0);
      check("rst imem_busy", imem_busy, 0);
      check("rst dmem_busy", dmem_busy, 0);
      check("rst inst_rdata", inst_rdata, 0);
      check("rst data_rdata", data_rdata, 0);
      tick();

      // Minimum-latency fetch, result held while the stage stalls.
      inst_req = 1; inst_addr = 32'hBFC00000; bus.mem_addr_ok = 1;
      #2;
      check("f0 busy", imem_busy, 1);
      check("f0 req", bus.mem_req, 0);
      tick();
      #2;
      check("f1 req", bus.mem_req, 1);
      check("f1 addr", bus.mem_addr, 32'hBFC00000);
      check("f1 busy", imem_busy, 1);
      tick();
      bus.mem_addr_ok = 0; bus.mem_data_ok = 1;
      bus.mem_rdata = 32'h3C080001;
      #2;
      check("f2 busy", imem_busy, 0);
      check("f2 rdata", inst_rdata, 32'h3C080001);
      tick();
      bus.mem_data_ok = 0; bus.mem_rdata = 32'hDEADBEEF;
      repeat (5) begin
         #2;
         check("hold busy", imem_busy, 0);
         check("hold rdata", inst_rdata, 32'h3C080001);
         check("hold req", bus.mem_req, 0);
         tick();
      end

      // Reset abandons a fetch waiting in its data phase.
      inst_accept = 1;
      tick();
      inst_accept = 0; inst_addr = 32'h00001000; bus.mem_addr_ok = 1;
      tick();
      tick();
      bus.mem_addr_ok = 0;
      rst = 1;
      tick();
      rst = 0;
      #2;
      check("rst2 req", bus.mem_req, 0);
      check("rst2 busy", imem_busy, 1);
      check("rst2 rdata", inst_rdata, 0);
      tick();

      // Random traffic against the model.
      for (int c = 0; c < 4000; c++) begin
         bus.mem_addr_ok = ($urandom % 3) != 0;
         bus.mem_data_ok = ($urandom % 3) != 0;
         bus.mem_rdata   = $urandom;
         rst = ($urandom % 400) == 0;
         if (!inst_req || inst_accept) begin
            inst_req  = ($urandom % 4) != 0;
            inst_addr = $urandom & 32'hFFFF_FFFC;
         end else if (($urandom % 25) == 0) begin
            inst_req = 0;
         end
         if (!data_req || data_accept) begin
            data_req   = ($urandom % 3) == 0;
            data_wr    = $urandom % 2;
            data_size  = 2'($urandom_range(0, 2));
            data_addr  = $urandom;
            data_wdata = $urandom;
         end else if (($urandom % 25) == 0) begin
            data_req = 0;
         end
         ib = inst_req && !m_idone &&
              !(comp_now() && !m_side);
         db = data_req && !m_ddone &&
              !(comp_now() && m_side);
         inst_accept = !ib && ($urandom % 2);
         data_accept = !db && ($urandom % 2);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
